// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, debounce FSM
// state encoding, per-frame scan result type and the row/column keymap.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } frame_res_e;

  function automatic logic [3:0] keyMap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_0;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-frame press/release debouncer for the keypad scanner. Consumes one
// scan result per frame and produces the accepted key, its one-cycle strobe
// and the held level. Optional auto-repeat under `KEYPAD_AUTOREPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_end_i,
  input  frame_res_e result_i,
  input  logic [3:0] code_i,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_down_o
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CNT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cntInc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;
  logic          isNone, isSingle;
  logic          repeatFire;

  assign isNone   = (result_i == RES_NONE);
  assign isSingle = (result_i == RES_SINGLE);
  assign cntInc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RepMax + 1);
  localparam logic [RW-1:0] RepDelay = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RepRate  = RW'(REPEAT_RATE);

  logic [RW-1:0] rep_q, rep_d, repNext;
  logic          repeating_q, repeating_d;

  // Count frames spent holding the reported key; fire after the initial delay, then at the rate
  always_comb begin
    rep_d       = rep_q;
    repeating_d = repeating_q;
    repeatFire  = 1'b0;
    repNext     = rep_q + RW'(1);
    if (state_q != HELD) begin
      rep_d       = '0;
      repeating_d = 1'b0;
    end else if (frame_end_i) begin
      if (isNone) begin
        rep_d       = '0;
        repeating_d = 1'b0;
      end else if (isSingle && (code_i == key_q)) begin
        if (repNext == (repeating_q ? RepRate : RepDelay)) begin
          repeatFire  = 1'b1;
          rep_d       = '0;
          repeating_d = 1'b1;
        end else begin
          rep_d = repNext;
        end
      end
    end
  end

  // Repeat counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rep_q       <= '0;
      repeating_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      repeating_q <= repeating_d;
    end
  end
`else
  logic unusedRepeatCfg;
  assign unusedRepeatCfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign repeatFire      = 1'b0;
`endif

  // Debounce FSM: advances only on the frame-end strobe, one scan result per frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    valid_d = 1'b0;
    down_d  = down_q;
    if (frame_end_i) begin
      case (state_q)
        IDLE: begin
          if (isSingle) begin
            cand_d = code_i;
            if (cntInc == CntMax) begin
              state_d = HELD;
              cnt_d   = '0;
              key_d   = code_i;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = cntInc;
            end
          end
        end
        PRESS_DB: begin
          if (isSingle && (code_i == cand_q)) begin
            if (cntInc == CntMax) begin
              state_d = HELD;
              cnt_d   = '0;
              key_d   = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (isNone) begin
            if (cntInc == CntMax) begin
              state_d = IDLE;
              cnt_d   = '0;
              down_d  = 1'b0;
            end else begin
              state_d = REL_DB;
              cnt_d   = cntInc;
            end
          end else begin
            valid_d = repeatFire;
          end
        end
        REL_DB: begin
          if (isNone) begin
            if (cntInc == CntMax) begin
              state_d = IDLE;
              cnt_d   = '0;
              down_d  = 1'b0;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and output registers; reset drops any press in progress without a strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_0;
      key_q   <= KEY_0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  assign key_o       = key_q;
  assign key_valid_o = valid_q;
  assign key_down_o  = down_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner/encoder: column driver, row synchroniser and
// frame decoder feeding keypad_debounce. Auto-repeat is enabled by defining
// `KEYPAD_AUTOREPEAT_EN; otherwise each debounced press strobes key_valid once.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DivLast = DW'(SCAN_DIV - 1);

  logic [3:0]    rowMeta_q, rowSync_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    colN_q, colN_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    rowsLow;
  logic [2:0]    colHits;
  logic [1:0]    hitRow;
  logic [1:0]    baseHits;
  logic [3:0]    baseCode;
  logic          sampleNow;
  logic          frameEnd;
  frame_res_e    frameRes;

  // Dwell counter, column rotation and per-frame hit accumulation over the four column samples
  always_comb begin
    rowsLow = ~rowSync_q;
    colHits = 3'd0;
    hitRow  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (rowsLow[r]) begin
        colHits = colHits + 3'd1;
        hitRow  = 2'(r);
      end
    end
    sampleNow = (div_q == DivLast);
    div_d     = sampleNow ? '0 : div_q + DW'(1);
    col_d     = sampleNow ? col_q + 2'd1 : col_q;
    colN_d    = ~(4'b0001 << col_d);
    baseHits  = (col_q == 2'd0) ? 2'd0 : hits_q;
    baseCode  = (col_q == 2'd0) ? KEY_0 : code_q;
    hits_d    = hits_q;
    code_d    = code_q;
    if (sampleNow) begin
      if (colHits >= 3'd2) begin
        hits_d = 2'd2;
        code_d = baseCode;
      end else if (colHits == 3'd1) begin
        hits_d = (baseHits == 2'd0) ? 2'd1 : 2'd2;
        code_d = (baseHits == 2'd0) ? keyMap(hitRow, col_q) : baseCode;
      end else begin
        hits_d = baseHits;
        code_d = baseCode;
      end
    end
    frameEnd = sampleNow && (col_q == 2'd3);
    case (hits_d)
      2'd0:    frameRes = RES_NONE;
      2'd1:    frameRes = RES_SINGLE;
      default: frameRes = RES_MULTI;
    endcase
  end

  // Synchroniser, scan position and accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
      div_q     <= '0;
      col_q     <= 2'd0;
      colN_q    <= 4'b1110;
      hits_q    <= 2'd0;
      code_q    <= KEY_0;
    end else begin
      rowMeta_q <= row_n;
      rowSync_q <= rowMeta_q;
      div_q     <= div_d;
      col_q     <= col_d;
      colN_q    <= colN_d;
      hits_q    <= hits_d;
      code_q    <= code_d;
    end
  end

  assign col_n = colN_q;

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_debounce (
    .clk_i      (clk),
    .reset_i    (reset),
    .frame_end_i(frameEnd),
    .result_i   (frameRes),
    .code_i     (code_d),
    .key_o      (key),
    .key_valid_o(key_valid),
    .key_down_o (key_down)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3, 16-cycle
// frames). A keypad model pulls rows low only while the matching column is
// driven. Repeat checks depend on `KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;

  localparam logic [15:0] K6    = 16'h0040;
  localparam logic [15:0] K0    = 16'h2000;
  localparam logic [15:0] K9    = 16'h0400;
  localparam logic [15:0] KHASH = 16'h4000;

  logic        clk;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed;

  int compared   = 0;
  int mismatched = 0;
  int pulseCnt   = 0;
  int edgeCnt    = 0;
  int base       = 0;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3),
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .key      (key),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed switch shorts its row to its column while that column is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Clock edges since the last reset release
  always @(posedge clk) begin
    if (reset) edgeCnt <= 0;
    else       edgeCnt <= edgeCnt + 1;
  end

  // Count key_valid strobes
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulseCnt <= pulseCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic goTo(input int t);
    while (edgeCnt < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    pressed = '0;
    waitCycles(2);
    reset   = 1'b0;
    base    = pulseCnt;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    pressed = '0;

    // 1: reset values, column rotation, idle keypad
    waitCycles(1);
    checkOutput("rst_col_n", 32'(col_n), 32'h E);
    checkOutput("rst_key", 32'(key), 32'h0);
    checkOutput("rst_key_valid", 32'(key_valid), 32'h0);
    checkOutput("rst_key_down", 32'(key_down), 32'h0);
    waitCycles(1);
    reset = 1'b0;
    base  = pulseCnt;
    checkOutput("scan_c0", 32'(col_n), 32'hE);
    goTo(4);  checkOutput("scan_c1", 32'(col_n), 32'hD);
    goTo(8);  checkOutput("scan_c2", 32'(col_n), 32'hB);
    goTo(12); checkOutput("scan_c3", 32'(col_n), 32'h7);
    goTo(16); checkOutput("scan_wrap", 32'(col_n), 32'hE);
    goTo(64);
    checkOutput("idle_pulses", 32'(pulseCnt - base), 32'd0);
    checkOutput("idle_key_down", 32'(key_down), 32'h0);

    // 2: clean "6" press, accept latency and release debounce
    doReset();
    applyStimulus(K6);
    goTo(47);
    checkOutput("t2_pre_valid", 32'(key_valid), 32'h0);
    checkOutput("t2_pre_pulses", 32'(pulseCnt - base), 32'd0);
    goTo(48);
    checkOutput("t2_valid", 32'(key_valid), 32'h1);
    checkOutput("t2_key", 32'(key), 32'h6);
    checkOutput("t2_down", 32'(key_down), 32'h1);
    goTo(49);
    checkOutput("t2_valid_one_cycle", 32'(key_valid), 32'h0);
    goTo(64);
    checkOutput("t2_pulses", 32'(pulseCnt - base), 32'd1);
    applyStimulus('0);
    goTo(111);
    checkOutput("t2_rel_down_hold", 32'(key_down), 32'h1);
    goTo(112);
    checkOutput("t2_rel_down", 32'(key_down), 32'h0);
    checkOutput("t2_rel_key", 32'(key), 32'h6);
    checkOutput("t2_rel_pulses", 32'(pulseCnt - base), 32'd1);

    // 3: "6" bounces on/off per frame, then holds
    doReset();
    for (int f = 0; f < 6; f++) begin
      applyStimulus((f % 2 == 0) ? K6 : 16'h0000);
      goTo(16 * (f + 1));
    end
    applyStimulus(K6);
    goTo(143);
    checkOutput("t3_bounce_pulses", 32'(pulseCnt - base), 32'd0);
    goTo(144);
    checkOutput("t3_valid", 32'(key_valid), 32'h1);
    checkOutput("t3_key", 32'(key), 32'h6);
    goTo(160);
    checkOutput("t3_pulses", 32'(pulseCnt - base), 32'd1);

    // 4: "0" held, "9" added, "0" released -> only "0" is reported
    doReset();
    applyStimulus(K0);
    goTo(48);
    checkOutput("t4_valid", 32'(key_valid), 32'h1);
    checkOutput("t4_key", 32'(key), 32'h0);
    goTo(64);
    applyStimulus(K0 | K9);
    goTo(96);
    checkOutput("t4_multi_pulses", 32'(pulseCnt - base), 32'd1);
    applyStimulus(K9);
    goTo(160);
    checkOutput("t4_nine_pulses", 32'(pulseCnt - base), 32'd1);
    checkOutput("t4_nine_key", 32'(key), 32'h0);
    checkOutput("t4_nine_down", 32'(key_down), 32'h1);
    applyStimulus('0);
    goTo(207);
    checkOutput("t4_rel_down_hold", 32'(key_down), 32'h1);
    goTo(208);
    checkOutput("t4_rel_down", 32'(key_down), 32'h0);
    checkOutput("t4_rel_key", 32'(key), 32'h0);

    // 5: reset during PRESS_DB with count 2
    doReset();
    applyStimulus(K6);
    goTo(40);
    checkOutput("t5_col_before", 32'(col_n), 32'hB);
    checkOutput("t5_down_before", 32'(key_down), 32'h0);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("t5_rst_col_n", 32'(col_n), 32'hE);
    checkOutput("t5_rst_valid", 32'(key_valid), 32'h0);
    checkOutput("t5_rst_down", 32'(key_down), 32'h0);
    waitCycles(1);
    reset = 1'b0;
    base  = pulseCnt;
    goTo(47);
    checkOutput("t5_no_early_pulse", 32'(pulseCnt - base), 32'd0);
    goTo(48);
    checkOutput("t5_reaccept", 32'(key_valid), 32'h1);
    checkOutput("t5_reaccept_key", 32'(key), 32'h6);

    // 6: hold "#" well past the repeat delay
    doReset();
    applyStimulus(KHASH);
    goTo(48);
    checkOutput("t6_valid", 32'(key_valid), 32'h1);
    checkOutput("t6_key", 32'(key), 32'hF);
`ifdef KEYPAD_AUTOREPEAT_EN
    goTo(111);
    checkOutput("t6_pre_rep1", 32'(key_valid), 32'h0);
    goTo(112);
    checkOutput("t6_rep1", 32'(key_valid), 32'h1);
    checkOutput("t6_rep1_key", 32'(key), 32'hF);
    goTo(144);
    checkOutput("t6_rep2", 32'(key_valid), 32'h1);
    goTo(176);
    checkOutput("t6_rep3", 32'(key_valid), 32'h1);
    goTo(192);
    checkOutput("t6_pulses", 32'(pulseCnt - base), 32'd4);
`else
    goTo(112);
    checkOutput("t6_no_repeat", 32'(key_valid), 32'h0);
    goTo(192);
    checkOutput("t6_pulses", 32'(pulseCnt - base), 32'd1);
    checkOutput("t6_down", 32'(key_down), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
